// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit.
// cpu_lsu_if carries the CPU request/response handshake. The CPU is the master.
// lsu_mem_if carries the data-memory port. The load/store unit is the master.

interface cpu_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic [4:0]        resp_rd;
  logic [1:0]        resp_exc;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_exc
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_exc
  );
endinterface

interface lsu_mem_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit sitting between the CPU memory stage and the data memory.
// It handles one access at a time: IDLE accepts a request, MEM waits for
// mem_ack, and RESP holds the result until the CPU takes it. Misaligned and
// illegal requests skip the memory and go straight to RESP with an exception.

module load_store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  cpu_lsu_if.slave   cpu,
  lsu_mem_if.master  mem
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       op_p0;
  logic [OFF_W-1:0] off_p0;

  logic             accept;
  logic [OFF_W-1:0] req_off;
  logic             req_illegal;
  logic             req_misal;
  logic [1:0]       req_exc;

  // Op codes 3, 6 and 11 (LD/LWU/SD) exist only on a 64-bit datapath.
  function automatic logic op_illegal(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: return 1'b0;
      4'd3, 4'd6, 4'd11:                               return (XLEN == 32);
      default:                                         return 1'b1;
    endcase
  endfunction

  // op[1:0] is log2 of the access size in bytes.
  function automatic logic addr_misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a[2:0];
    endcase
  endfunction

  // Mark the (1 << sz) byte lanes that start at the lane offset.
  function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    logic [BE_W-1:0] m;
    for (int i = 0; i < BE_W; i++) begin
      m[i] = (i >= int'(off)) && (i < int'(off) + (1 << sz));
    end
    return m;
  endfunction

  // Repeat the low (1 << sz) bytes of the store data across every lane.
  function automatic logic [XLEN-1:0] lane_replicate(input logic [1:0] sz, input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] r;
    for (int i = 0; i < BE_W; i++) begin
      r[8*i +: 8] = wd[8*(i & ((1 << sz) - 1)) +: 8];
    end
    return r;
  endfunction

  // Shift the addressed bytes down to bit 0, then sign- or zero-extend them.
  function automatic logic [XLEN-1:0] load_extend(input logic [3:0] op, input logic [OFF_W-1:0] off,
                                                  input logic [XLEN-1:0] word);
    logic [XLEN-1:0]    sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    logic signed [31:0] sw;
    sh  = word >> {off, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    sw  = sh[31:0];
    case (op[1:0])
      2'd0:    return op[2] ? XLEN'(sh[7:0])  : XLEN'(sb);
      2'd1:    return op[2] ? XLEN'(sh[15:0]) : XLEN'(shw);
      2'd2:    return op[2] ? XLEN'(sh[31:0]) : XLEN'(sw);
      default: return sh;
    endcase
  endfunction

  assign accept      = cpu.req_valid && (state == IDLE);
  assign req_off     = cpu.req_addr[OFF_W-1:0];
  assign req_illegal = op_illegal(cpu.req_op);
  assign req_misal   = addr_misaligned(cpu.req_op[1:0], cpu.req_addr[2:0]);
  assign req_exc     = req_illegal ? 2'd3 : (req_misal ? (cpu.req_op[3] ? 2'd2 : 2'd1) : 2'd0);
  assign cpu.req_ready = (state == IDLE);

  // Register the FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Choose the next state from the request, memory and response handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (req_exc != 2'd0) ? RESP : MEM;
      MEM:     if (mem.mem_ack) state_nxt = RESP;
      RESP:    if (cpu.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request, drive the memory port and hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0          <= '0;
      off_p0         <= '0;
      mem.mem_req    <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_be     <= '0;
      mem.mem_wdata  <= '0;
      cpu.resp_valid <= 1'b0;
      cpu.resp_rdata <= '0;
      cpu.resp_rd    <= '0;
      cpu.resp_exc   <= '0;
    end else begin
      case (state)
        // request accept: the request is decoded in the same cycle
        IDLE: begin
          if (accept) begin
            op_p0          <= cpu.req_op;
            off_p0         <= req_off;
            cpu.resp_rd    <= cpu.req_rd;
            cpu.resp_rdata <= '0;
            cpu.resp_exc   <= req_exc;
            if (req_exc != 2'd0) begin
              cpu.resp_valid <= 1'b1;
            end else begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= cpu.req_op[3];
              mem.mem_addr  <= {cpu.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem.mem_be    <= lane_mask(cpu.req_op[1:0], req_off);
              mem.mem_wdata <= lane_replicate(cpu.req_op[1:0], cpu.req_wdata);
            end
          end
        end
        // memory access: the mem_* outputs stay put until the memory acknowledges
        MEM: begin
          if (mem.mem_ack) begin
            mem.mem_req    <= 1'b0;
            cpu.resp_valid <= 1'b1;
            if (!op_p0[3]) cpu.resp_rdata <= load_extend(op_p0, off_p0, mem.mem_rdata);
          end
        end
        // response: the resp_* outputs are held until the CPU consumes them
        RESP: begin
          if (cpu.resp_ready) cpu.resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit. Two instances run side by side, one with
// XLEN=32 and one with XLEN=64, and sel picks which one gets the stimulus.
// The bench keeps a byte-addressed memory and a size/sign model of each
// access, and checks the DUT against them.

module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_ready;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  cpu_lsu_if #(.XLEN(32), .ADDR_W(32)) c32();
  lsu_mem_if #(.XLEN(32), .ADDR_W(32)) m32();
  cpu_lsu_if #(.XLEN(64), .ADDR_W(32)) c64();
  lsu_mem_if #(.XLEN(64), .ADDR_W(32)) m64();

  load_store_unit #(.XLEN(32), .ADDR_W(32)) u32 (.clk(clk), .rst_n(rst_n), .cpu(c32), .mem(m32));
  load_store_unit #(.XLEN(64), .ADDR_W(32)) u64 (.clk(clk), .rst_n(rst_n), .cpu(c64), .mem(m64));

  assign c32.req_valid  = req_valid & ~sel;
  assign c32.req_op     = req_op;
  assign c32.req_addr   = req_addr;
  assign c32.req_wdata  = req_wdata[31:0];
  assign c32.req_rd     = req_rd;
  assign c32.resp_ready = resp_ready & ~sel;
  assign m32.mem_ack    = mem_ack & ~sel;
  assign m32.mem_rdata  = mem_rdata[31:0];

  assign c64.req_valid  = req_valid & sel;
  assign c64.req_op     = req_op;
  assign c64.req_addr   = req_addr;
  assign c64.req_wdata  = req_wdata;
  assign c64.req_rd     = req_rd;
  assign c64.resp_ready = resp_ready & sel;
  assign m64.mem_ack    = mem_ack & sel;
  assign m64.mem_rdata  = mem_rdata;

  logic        o_req_ready, o_resp_valid, o_mem_req, o_mem_we;
  logic [63:0] o_resp_rdata, o_mem_wdata;
  logic [4:0]  o_resp_rd;
  logic [1:0]  o_resp_exc;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_be;

  assign o_req_ready  = sel ? c64.req_ready  : c32.req_ready;
  assign o_resp_valid = sel ? c64.resp_valid : c32.resp_valid;
  assign o_resp_rdata = sel ? c64.resp_rdata : {32'b0, c32.resp_rdata};
  assign o_resp_rd    = sel ? c64.resp_rd    : c32.resp_rd;
  assign o_resp_exc   = sel ? c64.resp_exc   : c32.resp_exc;
  assign o_mem_req    = sel ? m64.mem_req    : m32.mem_req;
  assign o_mem_we     = sel ? m64.mem_we     : m32.mem_we;
  assign o_mem_addr   = sel ? m64.mem_addr   : m32.mem_addr;
  assign o_mem_be     = sel ? m64.mem_be     : {4'b0, m32.mem_be};
  assign o_mem_wdata  = sel ? m64.mem_wdata  : {32'b0, m32.mem_wdata};

  int n_tests = 0;
  int n_fail  = 0;

  bit [7:0] bmem [longint];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected exception code, worked out from the op table and the alignment rule.
  function automatic logic [1:0] model_exc(input bit s, input logic [3:0] op, input logic [31:0] addr);
    int nb;
    bit legal;
    nb    = 1 << op[1:0];
    legal = (op <= 6) || (op >= 8 && op <= 11);
    if (!s && (op == 3 || op == 6 || op == 11)) legal = 0;
    if (!legal) return 2'd3;
    if ((addr % nb) != 0) return op[3] ? 2'd2 : 2'd1;
    return 2'd0;
  endfunction

  // Expected load result, assembled byte by byte from the model memory.
  function automatic logic [63:0] model_load(input bit s, input logic [3:0] op, input logic [31:0] addr);
    int nb;
    logic [63:0] v;
    nb = 1 << op[1:0];
    v  = '0;
    for (int b = 0; b < nb; b++) v |= 64'(bmem[longint'(addr) + b]) << (8 * b);
    if (!op[2] && nb < 8 && v[8*nb-1]) v |= ~64'(0) << (8 * nb);
    if (!s) v &= 64'h0000_0000_ffff_ffff;
    return v;
  endfunction

  function automatic logic [63:0] mem_word(input logic [31:0] a, input int nl);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nl; i++) v |= 64'(bmem[longint'(a) + i]) << (8 * i);
    return v;
  endfunction

  // Run one access to completion. The task checks the memory port and the
  // response against the model and returns what it observed.
  task automatic run(input bit s, input logic [3:0] op, input logic [31:0] addr, input logic [63:0] wd,
                     input logic [4:0] rd, input int lat, input int rhold,
                     output logic [63:0] g_rdata, output logic [1:0] g_exc,
                     output logic [7:0] g_be, output logic [63:0] g_wd);
    int nl, nb;
    logic [1:0]  ee;
    logic [63:0] er, ewd;
    logic [7:0]  ebe;
    logic [31:0] maddr;
    nl = s ? 8 : 4;
    nb = 1 << op[1:0];
    ee = model_exc(s, op, addr);
    er = (ee == 0 && !op[3]) ? model_load(s, op, addr) : 64'd0;
    ebe = 8'(((1 << nb) - 1) << (addr % nl));
    ewd = '0;
    for (int i = 0; i < nl; i++) ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
    maddr = addr - (addr % nl);
    g_be = '0;
    g_wd = '0;

    sel = s;
    #0;
    chk("req_ready_idle", o_req_ready, 1);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 0;
    req_op = 4'($urandom); req_addr = $urandom; req_wdata = {$urandom, $urandom};
    chk("req_ready_busy", o_req_ready, 0);
    if (ee != 0) begin
      chk("exc_mem_req", o_mem_req, 0);
    end else begin
      for (int i = 0; i <= lat; i++) begin
        chk("mem_req", o_mem_req, 1);
        chk("mem_we", o_mem_we, op[3]);
        chk("mem_addr", o_mem_addr, maddr);
        chk("mem_be", o_mem_be, ebe);
        chk("mem_wdata", o_mem_wdata, ewd);
        chk("resp_early", o_resp_valid, 0);
        g_be = o_mem_be;
        g_wd = o_mem_wdata;
        if (i == lat) begin
          mem_ack   = 1;
          mem_rdata = mem_word(maddr, nl);
        end
        @(posedge clk); #1;
        mem_ack   = 0;
        mem_rdata = {$urandom, $urandom};
      end
      if (op[3]) for (int b = 0; b < nb; b++) bmem[longint'(addr) + b] = wd[8*b +: 8];
      chk("mem_req_drop", o_mem_req, 0);
    end
    chk("resp_valid", o_resp_valid, 1);
    chk("resp_rdata", o_resp_rdata, er);
    chk("resp_rd", o_resp_rd, rd);
    chk("resp_exc", o_resp_exc, ee);
    g_rdata = o_resp_rdata;
    g_exc   = o_resp_exc;
    for (int i = 0; i < rhold; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      mem_ack = 0;
      chk("hold_valid", o_resp_valid, 1);
      chk("hold_rdata", o_resp_rdata, er);
      chk("hold_rd", o_resp_rd, rd);
      chk("hold_exc", o_resp_exc, ee);
      chk("hold_req_ready", o_req_ready, 0);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("resp_drop", o_resp_valid, 0);
    chk("req_ready_back", o_req_ready, 1);
  endtask

  typedef struct {
    bit          s;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [4:0]  rd;
    int          lat;
    int          rhold;
    logic [1:0]  exc;
    logic [63:0] rdata;
    logic [7:0]  be;
    logic [63:0] wdo;
  } vec_t;

  initial begin
    vec_t        tv[$];
    logic [63:0] gr, gw;
    logic [1:0]  ge;
    logic [7:0]  gb;

    rst_n = 0; sel = 0; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    resp_ready = 0; mem_ack = 0; mem_rdata = 0;

    // 0x10: 0x00008000, 0x20: 0x000000ff, 0x40: 0x80000000_7fffffff (little-endian)
    bmem[32'h11] = 8'h80;
    bmem[32'h20] = 8'hff;
    bmem[32'h40] = 8'hff; bmem[32'h41] = 8'hff; bmem[32'h42] = 8'hff; bmem[32'h43] = 8'h7f;
    bmem[32'h47] = 8'h80;

    tv.push_back('{0, 4'd1,  32'h10, 64'h0,    5'd1,  0, 0, 2'd0, 64'hffff8000, 8'h03, 64'h0});
    tv.push_back('{0, 4'd5,  32'h10, 64'h0,    5'd2,  0, 0, 2'd0, 64'h00008000, 8'h03, 64'h0});
    tv.push_back('{0, 4'd0,  32'h20, 64'h0,    5'd3,  0, 0, 2'd0, 64'hffffffff, 8'h01, 64'h0});
    tv.push_back('{0, 4'd4,  32'h20, 64'h0,    5'd4,  0, 0, 2'd0, 64'h000000ff, 8'h01, 64'h0});
    tv.push_back('{0, 4'd8,  32'h10, 64'h90,   5'd5,  0, 0, 2'd0, 64'h0,        8'h01, 64'h90909090});
    tv.push_back('{0, 4'd1,  32'h10, 64'h0,    5'd6,  0, 0, 2'd0, 64'hffff8090, 8'h03, 64'h0});
    tv.push_back('{0, 4'd9,  32'h22, 64'h1234, 5'd7,  1, 0, 2'd0, 64'h0,        8'h0c, 64'h12341234});
    tv.push_back('{0, 4'd2,  32'h12, 64'h0,    5'd8,  0, 0, 2'd1, 64'h0,        8'h00, 64'h0});
    tv.push_back('{0, 4'd9,  32'h13, 64'h55,   5'd9,  0, 0, 2'd2, 64'h0,        8'h00, 64'h0});
    tv.push_back('{0, 4'd3,  32'h10, 64'h0,    5'd10, 0, 0, 2'd3, 64'h0,        8'h00, 64'h0});
    tv.push_back('{0, 4'd7,  32'h10, 64'h0,    5'd11, 0, 0, 2'd3, 64'h0,        8'h00, 64'h0});
    tv.push_back('{0, 4'd2,  32'h20, 64'h0,    5'd17, 3, 4, 2'd0, 64'h123400ff, 8'h0f, 64'h0});
    tv.push_back('{1, 4'd2,  32'h44, 64'h0,    5'd12, 0, 0, 2'd0, 64'hffffffff_80000000, 8'hf0, 64'h0});
    tv.push_back('{1, 4'd6,  32'h44, 64'h0,    5'd13, 0, 0, 2'd0, 64'h00000000_80000000, 8'hf0, 64'h0});
    tv.push_back('{1, 4'd3,  32'h40, 64'h0,    5'd14, 2, 1, 2'd0, 64'h80000000_7fffffff, 8'hff, 64'h0});
    tv.push_back('{1, 4'd8,  32'h47, 64'haa,   5'd15, 0, 0, 2'd0, 64'h0,        8'h80, 64'haaaaaaaa_aaaaaaaa});

    // Outputs while reset is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_resp_rdata", o_resp_rdata, 0);
    chk("rst_resp_rd", o_resp_rd, 0);
    chk("rst_resp_exc", o_resp_exc, 0);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_be", o_mem_be, 0);
    chk("rst_mem_wdata", o_mem_wdata, 0);
    chk("rst64_req_ready", c64.req_ready, 1);
    chk("rst64_mem_req", m64.mem_req, 0);
    rst_n = 1;
    @(posedge clk); #1;

    for (int k = 0; k < tv.size(); k++) begin
      run(tv[k].s, tv[k].op, tv[k].addr, tv[k].wd, tv[k].rd, tv[k].lat, tv[k].rhold, gr, ge, gb, gw);
      chk($sformatf("vec%0d_exc", k), 64'(ge), 64'(tv[k].exc));
      chk($sformatf("vec%0d_rdata", k), gr, tv[k].rdata);
      if (tv[k].exc == 2'd0) begin
        chk($sformatf("vec%0d_be", k), 64'(gb), 64'(tv[k].be));
        chk($sformatf("vec%0d_wdata", k), gw, tv[k].wdo);
      end
    end

    // Reset while a load is waiting for its ack.
    sel = 0;
    #0;
    req_valid = 1; req_op = 4'd2; req_addr = 32'h10; req_wdata = 0; req_rd = 5'd3;
    @(posedge clk); #1;
    req_valid = 0;
    chk("mid_mem_req", o_mem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("async_mem_req", o_mem_req, 0);
    chk("async_resp_valid", o_resp_valid, 0);
    chk("async_req_ready", o_req_ready, 1);
    chk("async_mem_addr", o_mem_addr, 0);
    chk("async_mem_be", o_mem_be, 0);
    @(posedge clk); #1;
    rst_n = 1;
    mem_ack = 1; mem_rdata = 64'hdead_beef_dead_beef;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("late_ack_mem_req", o_mem_req, 0);
    chk("late_ack_resp_valid", o_resp_valid, 0);
    chk("late_ack_req_ready", o_req_ready, 1);
    run(0, 4'd2, 32'h10, 64'h0, 5'd3, 0, 0, gr, ge, gb, gw);
    chk("after_rst_lw", gr, 64'h00008090);

    // Random accesses against the model.
    for (int k = 0; k < 80; k++) begin
      run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'h100 + 32'($urandom_range(0, 63)),
          {$urandom, $urandom}, 5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
          gr, ge, gb, gw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store unit between the CPU memory stage and the data memory port. Accepts one load or store per request: computes lane byte enables, replicates store data across lanes, then aligns and sign- or zero-extends load data. Detects misaligned and unsupported accesses and reports them without touching memory. Generalises the fixed 32-bit byte/half/word path to XLEN 32 or 64, and to a variable-latency memory handshake.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- ADDR_W, 32, byte-address width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit idle, request accepted when req_valid&&req_ready
- req_op  in  4  0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU, 8 SB, 9 SH, 10 SW, 11 SD; other codes illegal
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-justified
- req_rd  in  5  destination register tag, returned unchanged
- resp_valid  out  1  response present
- resp_ready  in  1  CPU consumes response
- resp_rdata  out  XLEN  extended load data; 0 for stores and exceptions
- resp_rd  out  5  tag of the completed request
- resp_exc  out  2  0 none, 1 load misaligned, 2 store misaligned, 3 illegal op
- mem_req  out  1  memory access request
- mem_we  out  1  1 store, 0 load
- mem_addr  out  ADDR_W  address aligned to XLEN/8 (low log2(XLEN/8) bits zero)
- mem_be  out  XLEN/8  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  XLEN  lane-replicated store data
- mem_ack  in  1  memory completes; mem_rdata valid in same cycle
- mem_rdata  in  XLEN  full aligned memory word

## Operation
- FSM states: IDLE, MEM, RESP. req_ready = (state==IDLE).
- IDLE: on accept, latch op, addr, wdata, rd. If the op is legal and aligned, go to MEM; otherwise latch exc, go to RESP with no memory access.
- Size: B=1, H=2, W=4, D=8 bytes. Misaligned when addr mod size != 0. Illegal: undefined codes; LD/LWU/SD when XLEN=32. Illegal takes priority over misaligned.
- Offset = addr[log2(XLEN/8)-1:0]. mem_be = ((1<<size)-1) << offset. mem_wdata = low size bytes of req_wdata repeated across all lanes.
- MEM: mem_req=1. mem_we, mem_addr, mem_be, mem_wdata held stable until mem_ack. On mem_ack, loads capture (mem_rdata >> 8*offset) truncated to size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU/LD). Next state RESP.
- RESP: resp_valid=1; resp_rdata, resp_rd, resp_exc held until resp_ready. On resp_ready, go to IDLE.
- mem_ack outside MEM is ignored. resp_ready outside RESP is ignored.
- Reset (any state, including mid-MEM): immediately IDLE, mem_req=0, resp_valid=0, all registered outputs 0. The memory side must tolerate an abandoned request; a late mem_ack is ignored.

## Timing
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_rdata=0, resp_rd=0, resp_exc=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- Accept at edge N. mem_req is high in cycle N+1. With mem_ack in N+1, resp_valid is high in N+2.
- Each cycle without mem_ack adds one cycle of latency.
- Exception path: accept at N, resp_valid in N+1, mem_req never asserted.
- With resp_ready tied high, resp_valid lasts one cycle and req_ready returns the following cycle. Peak throughput is one access per 3 cycles.
- All outputs are registered except req_ready, which is decoded from state.

## Test plan
- XLEN=32, mem word 0x00008000 at 0x10, ack immediate: LH 0x10 -> resp_rdata 0xffff8000; LHU 0x10 -> 0x00008000. Each response appears 2 cycles after accept.
- Word 0x000000ff at 0x20: LB 0x20 -> 0xffffffff; LBU 0x20 -> 0x000000ff. Then SB data 0x90 at 0x10 -> mem_be 4'b0001, mem_wdata 0x90909090, mem_addr 0x10; model memory becomes 0x00008090, and a following LH 0x10 -> 0xffff8090. Also SH data 0x1234 at 0x22 -> mem_be 4'b1100, mem_wdata 0x12341234.
- Misaligned/illegal: LW 0x12 -> resp_exc 1, resp_rdata 0; SH 0x13 -> resp_exc 2; LD with XLEN=32 -> resp_exc 3; op 7 -> resp_exc 3. mem_req stays 0 and resp_valid rises 1 cycle after accept.
- Wait states and backpressure: mem_ack delayed 3 cycles -> mem_* outputs stable throughout and resp_valid 5 cycles after accept. resp_ready held low 4 cycles -> resp_* held and req_ready stays 0. resp_rd echoes tag 17.
- XLEN=64, word 0x80000000_7fffffff at 0x40: LW 0x44 -> 0xffffffff_80000000; LWU 0x44 -> 0x00000000_80000000; LD 0x40 -> full value; SB 0xaa at 0x47 -> mem_be 8'h80.
- Reset mid-MEM: rst_n low while mem_req=1 -> mem_req=0 with no clock edge. After release: IDLE, req_ready=1, a spurious mem_ack is ignored, and the next LW completes normally.
